// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-memory slave for the CPU load/store port.
// It holds 64-bit words and supports byte, half, word and double accesses.
// Stores merge only the selected byte lanes. Loads are sign- or zero-extended.
// Each access completes LATENCY wait states after it is accepted.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors.
// Such accesses return zero data and do not write memory.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [63:0] mem [DEPTH_WORDS];

  // Access decode, derived from the latched request.
  logic [2:0]       off;
  logic             in_range;
  logic             misalign;
  logic             acc_err;
  logic [IDX_W-1:0] word_idx;
  logic [7:0]       base_mask;
  logic [7:0]       lane_mask;
  logic [63:0]      wdata_shift;
  logic [63:0]      rd_word;
  logic [63:0]      rd_shift;
  logic [63:0]      load_data;
  logic             do_access;
  logic             mem_we;

  assign off         = addr_q[2:0];
  assign in_range    = (addr_q[63:3] < 61'(DEPTH_WORDS));
  assign word_idx    = addr_q[3 +: IDX_W];
  assign acc_err     = !in_range || misalign;
  assign wdata_shift = wdata_q << {off, 3'b000};
  assign rd_word     = mem[word_idx];
  assign rd_shift    = rd_word >> {off, 3'b000};
  assign mem_we      = do_access && we_q && !acc_err;

`ifdef DMEM_MISALIGN_TRAP_EN
  // Flag an address that is not a multiple of the access size.
  always_comb begin
    misalign = 1'b0;
    case (size_q)
      2'b01:   misalign = addr_q[0];
      2'b10:   misalign = |addr_q[1:0];
      2'b11:   misalign = |addr_q[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Byte-lane mask. Lanes shifted past byte 7 fall off the 8-bit result.
  always_comb begin
    base_mask = 8'h01;
    case (size_q)
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    lane_mask = base_mask << off;
  end

  // Load data: truncate the shifted word to the access size, then extend it.
  always_comb begin
    load_data = rd_shift;
    case (size_q)
      2'b00:   load_data = uns_q ? {56'd0, rd_shift[7:0]}
                                 : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = uns_q ? {48'd0, rd_shift[15:0]}
                                 : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   load_data = uns_q ? {32'd0, rd_shift[31:0]}
                                 : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Next-state and response logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    do_access   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          count_d = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (count_q == 4'd0) begin
          do_access   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? 64'd0 : load_data;
          state_d     = ST_RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Data and error keep their values after the handshake. Only valid drops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers. Reset abandons any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 64'd0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 64'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane merge into the storage array at the access edge.
  // NOTE: the array has no reset so it can map onto RAM. A store that completed before reset persists.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wdata_shift[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
